// File: rtl/xgmii_rx_frame_checker.sv
// Link-test sink on the 64-bit XGMII receive stream: classifies each registered word,
// checks word-aligned incrementing-counter frames and keeps saturating statistics.
module xgmii_rx_frame_checker #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 32
) (
    input  logic             usclk,
    input  logic             ext_rst_n,
    input  logic [63:0]      xgmii_rxd,
    input  logic [7:0]       xgmii_rxc,
    input  logic             link_up,
    input  logic             clr_stats,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             in_frame,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] stray_cnt,
    output logic [15:0]      last_len
);

    localparam logic [63:0] IDLE_WORD  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] START_WORD = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] TERM_WORD  = 64'h0707_0707_0707_07FD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_START = 3'd1;
    localparam logic [2:0] C_DATA  = 3'd2;
    localparam logic [2:0] C_TERM  = 3'd3;
    localparam logic [2:0] C_BAD   = 3'd4;

    localparam logic [15:0]      MAX_LEN = 16'(MAX_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [63:0]      rxd_q;
    logic [7:0]       rxc_q;
    logic [2:0]       cls;
    logic [1:0]       state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic             sticky_q, sticky_d;
    logic [63:0]      exp_word_q, exp_word_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_err_cnt_q, word_err_cnt_d;
    logic [CNT_W-1:0] stray_cnt_q, stray_cnt_d;
    logic [15:0]      last_len_q, last_len_d;
    logic             end_frame, end_err, word_err, stray;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c,
                                              input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && c != '1) return c + CNT_ONE;
        return c;
    endfunction

    always_comb begin
        cls = C_BAD;
        if (rxc_q == 8'hFF && rxd_q == IDLE_WORD) cls = C_IDLE;
        else if (rxc_q == 8'h01 && rxd_q == START_WORD) cls = C_START;
        else if (rxc_q == 8'h00) cls = C_DATA;
        else if (rxc_q == 8'hFF && rxd_q == TERM_WORD) cls = C_TERM;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sticky_d   = sticky_q;
        exp_word_d = exp_word_q;
        end_frame  = 1'b0;
        end_err    = 1'b0;
        word_err   = 1'b0;
        stray      = 1'b0;
        // Losing the link silently discards whatever frame was in flight.
        if (!link_up) begin
            state_d  = ST_IDLE;
            len_d    = '0;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cls == C_START) begin
                        state_d  = ST_DATA;
                        len_d    = '0;
                        sticky_d = 1'b0;
                    end else if (cls != C_IDLE) begin
                        stray = 1'b1;
                    end
                end
                ST_DATA: begin
                    case (cls)
                        C_DATA: begin
                            if (len_q == MAX_LEN) begin
                                end_frame = 1'b1;
                                end_err   = 1'b1;
                                state_d   = ST_DROP;
                            end else begin
                                // First word seeds the counter; later words resync on mismatch.
                                if (len_q != 16'd0 && rxd_q != exp_word_q) begin
                                    word_err = 1'b1;
                                    sticky_d = 1'b1;
                                end
                                exp_word_d = rxd_q + 64'd1;
                                len_d      = len_q + 16'd1;
                            end
                        end
                        C_TERM: begin
                            end_frame = 1'b1;
                            end_err   = (len_q == 16'd0) || sticky_q;
                            state_d   = ST_IDLE;
                        end
                        C_START: begin
                            end_frame = 1'b1;
                            end_err   = 1'b1;
                            len_d     = '0;
                            sticky_d  = 1'b0;
                        end
                        default: begin
                            end_frame = 1'b1;
                            end_err   = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    endcase
                end
                ST_DROP: begin
                    if (cls == C_TERM || cls == C_IDLE) begin
                        state_d = ST_IDLE;
                    end else if (cls == C_START) begin
                        state_d  = ST_DATA;
                        len_d    = '0;
                        sticky_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ok_d     = end_frame & ~end_err;
        frame_err_d    = end_frame & end_err;
        frame_cnt_d    = bump(frame_cnt_q, end_frame, clr_stats);
        err_cnt_d      = bump(err_cnt_q, end_frame & end_err, clr_stats);
        word_err_cnt_d = bump(word_err_cnt_q, word_err, clr_stats);
        stray_cnt_d    = bump(stray_cnt_q, stray, clr_stats);
        last_len_d     = clr_stats ? 16'd0 : (end_frame ? len_q : last_len_q);
    end

    always_ff @(posedge usclk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            rxd_q          <= IDLE_WORD;
            rxc_q          <= 8'hFF;
            state_q        <= ST_IDLE;
            len_q          <= '0;
            sticky_q       <= 1'b0;
            exp_word_q     <= '0;
            frame_ok_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
            word_err_cnt_q <= '0;
            stray_cnt_q    <= '0;
            last_len_q     <= '0;
        end else begin
            rxd_q          <= xgmii_rxd;
            rxc_q          <= xgmii_rxc;
            state_q        <= state_d;
            len_q          <= len_d;
            sticky_q       <= sticky_d;
            exp_word_q     <= exp_word_d;
            frame_ok_q     <= frame_ok_d;
            frame_err_q    <= frame_err_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
            word_err_cnt_q <= word_err_cnt_d;
            stray_cnt_q    <= stray_cnt_d;
            last_len_q     <= last_len_d;
        end
    end

    assign frame_ok     = frame_ok_q;
    assign frame_err    = frame_err_q;
    assign in_frame     = (state_q == ST_DATA);
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign word_err_cnt = word_err_cnt_q;
    assign stray_cnt    = stray_cnt_q;
    assign last_len     = last_len_q;

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
// Bench for xgmii_rx_frame_checker: fixed vector table, directed corner sequences and
// random traffic, all checked against a frame-level model built on a payload queue.
module tb_xgmii_rx_frame_checker;

    localparam int MAXW = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [63:0] W_IDLE  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] W_START = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] W_TERM  = 64'h0707_0707_0707_07FD;
    localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_TERM = 3, K_BAD = 4;

    logic          usclk = 1'b0;
    logic          ext_rst_n, link_up, clr_stats;
    logic [63:0]   rxd;
    logic [7:0]    rxc;
    logic          frame_ok, frame_err, in_frame;
    logic [CW-1:0] frame_cnt, err_cnt, word_err_cnt, stray_cnt;
    logic [15:0]   last_len;

    xgmii_rx_frame_checker #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .usclk(usclk), .ext_rst_n(ext_rst_n), .xgmii_rxd(rxd), .xgmii_rxc(rxc),
        .link_up(link_up), .clr_stats(clr_stats), .frame_ok(frame_ok),
        .frame_err(frame_err), .in_frame(in_frame), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .word_err_cnt(word_err_cnt), .stray_cnt(stray_cnt),
        .last_len(last_len)
    );

    always #5 usclk = ~usclk;

    int n_vec = 0, n_mis = 0, stepn = 0, n_okp = 0, n_errp = 0;

    // Model: the word waiting in the DUT input register plus a frame-level view.
    logic [63:0] m_prev_d;
    logic [7:0]  m_prev_c;
    logic [63:0] m_pay[$];
    int m_in, m_drop, m_ok, m_err, m_fcnt, m_ecnt, m_wcnt, m_scnt, m_llen;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        int ok, err, inf, fc, ec, wc, sc, ll;
    } vec_t;

    function automatic vec_t mk(input logic [63:0] d, input logic [7:0] c, input int ok,
                                input int err, input int inf, input int fc, input int ec,
                                input int wc, input int sc, input int ll);
        vec_t v;
        v.d = d; v.c = c; v.ok = ok; v.err = err; v.inf = inf;
        v.fc = fc; v.ec = ec; v.wc = wc; v.sc = sc; v.ll = ll;
        return v;
    endfunction

    function automatic int classify(input logic [63:0] d, input logic [7:0] c);
        if (c == 8'hFF && d == W_IDLE) return K_IDLE;
        if (c == 8'h01 && d == W_START) return K_START;
        if (c == 8'h00) return K_DATA;
        if (c == 8'hFF && d == W_TERM) return K_TERM;
        return K_BAD;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    function automatic int has_gap();
        for (int i = 1; i < m_pay.size(); i++)
            if (m_pay[i] != m_pay[i-1] + 64'd1) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_prev_d = W_IDLE; m_prev_c = 8'hFF; m_pay.delete();
        m_in = 0; m_drop = 0; m_ok = 0; m_err = 0;
        m_fcnt = 0; m_ecnt = 0; m_wcnt = 0; m_scnt = 0; m_llen = 0;
    endtask

    task automatic close_frame(input int bad);
        if (bad != 0) m_err = 1; else m_ok = 1;
        m_fcnt = sat_inc(m_fcnt);
        if (bad != 0) m_ecnt = sat_inc(m_ecnt);
        m_llen = m_pay.size();
    endtask

    task automatic model_step(input logic lk, input logic cl);
        int k;
        k = classify(m_prev_d, m_prev_c);
        m_ok = 0; m_err = 0;
        if (!lk) begin
            m_in = 0; m_drop = 0; m_pay.delete();
        end else if (m_in != 0) begin
            if (k == K_DATA) begin
                if (m_pay.size() == MAXW) begin
                    close_frame(1); m_in = 0; m_drop = 1;
                end else begin
                    if (m_pay.size() > 0 && m_prev_d != m_pay[$] + 64'd1) m_wcnt = sat_inc(m_wcnt);
                    m_pay.push_back(m_prev_d);
                end
            end else if (k == K_TERM) begin
                close_frame((m_pay.size() == 0 || has_gap() != 0) ? 1 : 0); m_in = 0;
            end else if (k == K_START) begin
                close_frame(1); m_pay.delete();
            end else begin
                close_frame(1); m_in = 0;
            end
        end else if (k == K_START) begin
            m_in = 1; m_drop = 0; m_pay.delete();
        end else if (m_drop != 0) begin
            if (k == K_TERM || k == K_IDLE) m_drop = 0;
        end else if (k != K_IDLE) begin
            m_scnt = sat_inc(m_scnt);
        end
        if (cl) begin
            m_fcnt = 0; m_ecnt = 0; m_wcnt = 0; m_scnt = 0; m_llen = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, stepn, got, exp);
        end
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic lk, input logic cl);
        rxd = d; rxc = c; link_up = lk; clr_stats = cl;
        @(posedge usclk);
        #1;
        stepn++;
        model_step(lk, cl);
        m_prev_d = d; m_prev_c = c;
        chk("frame_ok", 64'(frame_ok), 64'(m_ok));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("in_frame", 64'(in_frame), 64'(m_in));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
        chk("err_cnt", 64'(err_cnt), 64'(m_ecnt));
        chk("word_err_cnt", 64'(word_err_cnt), 64'(m_wcnt));
        chk("stray_cnt", 64'(stray_cnt), 64'(m_scnt));
        chk("last_len", 64'(last_len), 64'(m_llen));
        if (frame_ok) n_okp++;
        if (frame_err) n_errp++;
    endtask

    task automatic s_i();                  step(W_IDLE, 8'hFF, 1'b1, 1'b0); endtask
    task automatic s_s();                  step(W_START, 8'h01, 1'b1, 1'b0); endtask
    task automatic s_t();                  step(W_TERM, 8'hFF, 1'b1, 1'b0); endtask
    task automatic s_d(input logic [63:0] x); step(x, 8'h00, 1'b1, 1'b0); endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ok"}, 64'(frame_ok), 64'd0);
        chk({nm, "_err"}, 64'(frame_err), 64'd0);
        chk({nm, "_inf"}, 64'(in_frame), 64'd0);
        chk({nm, "_fcnt"}, 64'(frame_cnt), 64'd0);
        chk({nm, "_ecnt"}, 64'(err_cnt), 64'd0);
        chk({nm, "_wcnt"}, 64'(word_err_cnt), 64'd0);
        chk({nm, "_scnt"}, 64'(stray_cnt), 64'd0);
        chk({nm, "_llen"}, 64'(last_len), 64'd0);
    endtask

    initial begin
        vec_t tbl[28];
        int fc0, ec0, wc0, sc0, ll0, ok0, er0;
        logic [63:0] nxt, bw;

        tbl[0]  = mk(W_IDLE, 8'hFF, 0,0,0, 0,0,0,0, 0);
        tbl[1]  = mk(W_IDLE, 8'hFF, 0,0,0, 0,0,0,0, 0);
        tbl[2]  = mk(W_IDLE, 8'hFF, 0,0,0, 0,0,0,0, 0);
        tbl[3]  = mk(W_IDLE, 8'hFF, 0,0,0, 0,0,0,0, 0);
        tbl[4]  = mk(W_START, 8'h01, 0,0,0, 0,0,0,0, 0);
        tbl[5]  = mk(64'h10, 8'h00, 0,0,1, 0,0,0,0, 0);
        tbl[6]  = mk(64'h11, 8'h00, 0,0,1, 0,0,0,0, 0);
        tbl[7]  = mk(64'h12, 8'h00, 0,0,1, 0,0,0,0, 0);
        tbl[8]  = mk(64'h13, 8'h00, 0,0,1, 0,0,0,0, 0);
        tbl[9]  = mk(W_TERM, 8'hFF, 0,0,1, 0,0,0,0, 0);
        tbl[10] = mk(W_IDLE, 8'hFF, 1,0,0, 1,0,0,0, 4);
        tbl[11] = mk(W_IDLE, 8'hFF, 0,0,0, 1,0,0,0, 4);
        tbl[12] = mk(W_START, 8'h01, 0,0,0, 1,0,0,0, 4);
        tbl[13] = mk(64'd5, 8'h00, 0,0,1, 1,0,0,0, 4);
        tbl[14] = mk(64'd6, 8'h00, 0,0,1, 1,0,0,0, 4);
        tbl[15] = mk(64'd9, 8'h00, 0,0,1, 1,0,0,0, 4);
        tbl[16] = mk(64'd10, 8'h00, 0,0,1, 1,0,1,0, 4);
        tbl[17] = mk(W_TERM, 8'hFF, 0,0,1, 1,0,1,0, 4);
        tbl[18] = mk(W_IDLE, 8'hFF, 0,1,0, 2,1,1,0, 4);
        tbl[19] = mk(W_IDLE, 8'hFF, 0,0,0, 2,1,1,0, 4);
        tbl[20] = mk(64'd1, 8'h00, 0,0,0, 2,1,1,0, 4);
        tbl[21] = mk(64'd2, 8'h00, 0,0,0, 2,1,1,1, 4);
        tbl[22] = mk(64'd3, 8'h00, 0,0,0, 2,1,1,2, 4);
        tbl[23] = mk(W_IDLE, 8'hFF, 0,0,0, 2,1,1,3, 4);
        tbl[24] = mk(W_START, 8'h01, 0,0,0, 2,1,1,3, 4);
        tbl[25] = mk(W_TERM, 8'hFF, 0,0,1, 2,1,1,3, 4);
        tbl[26] = mk(W_IDLE, 8'hFF, 0,1,0, 3,2,1,3, 0);
        tbl[27] = mk(W_IDLE, 8'hFF, 0,0,0, 3,2,1,3, 0);

        ext_rst_n = 1'b0; link_up = 1'b0; clr_stats = 1'b0; rxd = W_IDLE; rxc = 8'hFF;
        model_reset();
        #12;
        chk_all_zero("reset");
        ext_rst_n = 1'b1;

        // Good frame, payload error, stray words, START then TERM.
        for (int i = 0; i < 28; i++) begin
            step(tbl[i].d, tbl[i].c, 1'b1, 1'b0);
            chk("tbl_ok", 64'(frame_ok), 64'(tbl[i].ok));
            chk("tbl_err", 64'(frame_err), 64'(tbl[i].err));
            chk("tbl_inf", 64'(in_frame), 64'(tbl[i].inf));
            chk("tbl_fcnt", 64'(frame_cnt), 64'(tbl[i].fc));
            chk("tbl_ecnt", 64'(err_cnt), 64'(tbl[i].ec));
            chk("tbl_wcnt", 64'(word_err_cnt), 64'(tbl[i].wc));
            chk("tbl_scnt", 64'(stray_cnt), 64'(tbl[i].sc));
            chk("tbl_llen", 64'(last_len), 64'(tbl[i].ll));
        end

        // Overlong frame: 5th word ends it, following DATA and TERM are swallowed.
        fc0 = int'(frame_cnt); sc0 = int'(stray_cnt); er0 = n_errp;
        s_s(); s_d(64'd1); s_d(64'd2); s_d(64'd3); s_d(64'd4); s_d(64'd5);
        s_d(64'd6);
        chk("max_err_now", 64'(frame_err), 64'd1);
        s_t(); s_i(); s_i();
        chk("max_fcnt", 64'(frame_cnt), 64'(fc0 + 1));
        chk("max_errp", 64'(n_errp - er0), 64'd1);
        chk("max_stray", 64'(stray_cnt), 64'(sc0));
        chk("max_llen", 64'(last_len), 64'(MAXW));

        // Counter wrap across 64 bits.
        wc0 = int'(word_err_cnt); ok0 = n_okp;
        s_s(); s_d(64'hFFFF_FFFF_FFFF_FFFF); s_d(64'd0); s_d(64'd1); s_t(); s_i(); s_i();
        chk("wrap_wcnt", 64'(word_err_cnt), 64'(wc0));
        chk("wrap_okp", 64'(n_okp - ok0), 64'd1);

        // START inside a frame restarts it.
        fc0 = int'(frame_cnt); ok0 = n_okp; er0 = n_errp;
        s_s(); s_d(64'd1); s_d(64'd2); s_s(); s_d(64'd7); s_d(64'd8); s_t(); s_i(); s_i();
        chk("restart_fcnt", 64'(frame_cnt), 64'(fc0 + 2));
        chk("restart_okp", 64'(n_okp - ok0), 64'd1);
        chk("restart_errp", 64'(n_errp - er0), 64'd1);
        chk("restart_llen", 64'(last_len), 64'd2);

        // Error control code in lane 3 mid-frame.
        s_s(); s_d(64'd1); step(64'h0000_0000_FE00_0000, 8'h08, 1'b1, 1'b0); s_i();
        chk("fe_err", 64'(frame_err), 64'd1);
        chk("fe_inf", 64'(in_frame), 64'd0);
        s_i();

        // Link drop mid-frame: frame vanishes with no trace.
        s_s(); s_d(64'd1); s_d(64'd2);
        fc0 = int'(frame_cnt); ec0 = int'(err_cnt); wc0 = int'(word_err_cnt);
        sc0 = int'(stray_cnt); ll0 = int'(last_len); ok0 = n_okp; er0 = n_errp;
        step(64'd3, 8'h00, 1'b0, 1'b0);
        chk("link_inf", 64'(in_frame), 64'd0);
        step(W_IDLE, 8'hFF, 1'b0, 1'b0); s_i(); s_i();
        chk("link_fcnt", 64'(frame_cnt), 64'(fc0));
        chk("link_ecnt", 64'(err_cnt), 64'(ec0));
        chk("link_wcnt", 64'(word_err_cnt), 64'(wc0));
        chk("link_scnt", 64'(stray_cnt), 64'(sc0));
        chk("link_llen", 64'(last_len), 64'(ll0));
        chk("link_pulses", 64'((n_okp - ok0) + (n_errp - er0)), 64'd0);

        // Clear coinciding with a good frame end.
        s_s(); s_d(64'd1); s_t(); step(W_IDLE, 8'hFF, 1'b1, 1'b1);
        chk("clr_ok", 64'(frame_ok), 64'd1);
        chk("clr_fcnt", 64'(frame_cnt), 64'd0);
        chk("clr_llen", 64'(last_len), 64'd0);
        s_i();

        // Asynchronous reset mid-frame.
        s_s(); s_d(64'd1); s_d(64'd2);
        #1 ext_rst_n = 1'b0;
        #1 chk_all_zero("arst");
        model_reset();
        #1 ext_rst_n = 1'b1;

        // Stray words saturate their counter.
        for (int i = 0; i < 300; i++) s_d(64'(i));
        chk("sat_scnt", 64'(stray_cnt), 64'(CMAX));
        s_i();
        step(W_IDLE, 8'hFF, 1'b1, 1'b1);

        nxt = 64'd0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic lk, cl;
            r  = int'($urandom_range(0, 99));
            lk = ($urandom_range(0, 49) != 0);
            cl = ($urandom_range(0, 99) == 0);
            if (r < 10) step(W_IDLE, 8'hFF, lk, cl);
            else if (r < 22) step(W_START, 8'h01, lk, cl);
            else if (r < 62) begin step(nxt, 8'h00, lk, cl); nxt = nxt + 64'd1; end
            else if (r < 68) begin
                nxt = {$urandom, $urandom};
                step(nxt, 8'h00, lk, cl);
                nxt = nxt + 64'd1;
            end
            else if (r < 85) step(W_TERM, 8'hFF, lk, cl);
            else if (r < 92) step({$urandom, $urandom}, 8'($urandom_range(1, 255)), lk, cl);
            else begin
                bw = W_IDLE;
                bw[8*$urandom_range(0, 7) +: 8] = 8'hFE;
                step(bw, 8'hFF, lk, cl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
